alu_seq: RTL



---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops finish in one
// clock; mul/divu/remu iterate one bit per clock over a shared hi/lo register pair.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carryout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_LSL  = 4'b0101;
    localparam logic [3:0] OP_LSR  = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_ASR  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_ASL  = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [SHW:0]     count;

    assign dbg_state = state;

    // Single-cycle datapath, evaluated on the live inputs at accept time.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] s_res;
    logic             s_c;
    logic             s_v;
    logic             s_valid;
    logic             start_iter;

    always_comb begin
        sum     = {1'b0, srca} + {1'b0, srcb};
        diff    = {1'b0, srca} - {1'b0, srcb};
        s_res   = '0;
        s_c     = 1'b0;
        s_v     = 1'b0;
        s_valid = 1'b1;
        case (alu_op)
            OP_ADD: begin
                s_res = sum[WIDTH-1:0];
                s_c   = sum[WIDTH];
                s_v   = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
            end
            OP_SUB: begin
                s_res = diff[WIDTH-1:0];
                s_c   = ~diff[WIDTH];
                s_v   = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);
            end
            OP_AND:  s_res = srca & srcb;
            OP_OR:   s_res = srca | srcb;
            OP_XOR:  s_res = srca ^ srcb;
            OP_LSL,
            OP_ASL:  s_res = srca << srcb[SHW-1:0];
            OP_LSR:  s_res = srca >> srcb[SHW-1:0];
            OP_MOV:  s_res = srcb;
            OP_ASR:  s_res = WIDTH'($signed(srca) >>> srcb[SHW-1:0]);
            OP_SLTU: s_res = {{(WIDTH-1){1'b0}}, srca < srcb};
            OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            OP_DIVU: s_res = '1;     // only reached when srcb == 0
            OP_REMU: s_res = srca;   // only reached when srcb == 0
            default: s_valid = 1'b0;
        endcase
        start_iter = (alu_op == OP_MUL) ||
                     (((alu_op == OP_DIVU) || (alu_op == OP_REMU)) && (srcb != '0));
    end

    // One iteration step: shift-add multiply or restoring divide on {hi, lo}.
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] n_hi;
    logic [WIDTH-1:0] n_lo;
    logic [WIDTH-1:0] m_res;
    logic             m_c;

    always_comb begin
        msum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        trial = {hi, lo[WIDTH-1]} - {1'b0, opnd};
        m_c   = 1'b0;
        if (op_q == OP_MUL) begin
            n_hi  = msum[WIDTH:1];
            n_lo  = {msum[0], lo[WIDTH-1:1]};
            m_res = n_lo;
            m_c   = (n_hi != '0);
        end else begin
            if (!trial[WIDTH]) begin
                n_hi = trial[WIDTH-1:0];
                n_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                n_hi = {hi[WIDTH-2:0], lo[WIDTH-1]};
                n_lo = {lo[WIDTH-2:0], 1'b0};
            end
            m_res = (op_q == OP_REMU) ? n_hi : n_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            op_q      <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= alu_op;
                        in_ready <= 1'b0;
                        if (start_iter) begin
                            // mul walks B's bits in lo; divide shifts the dividend out of lo
                            hi    <= '0;
                            lo    <= (alu_op == OP_MUL) ? srcb : srca;
                            opnd  <= (alu_op == OP_MUL) ? srca : srcb;
                            count <= '0;
                            state <= BUSY;
                        end else begin
                            result    <= s_res;
                            zero      <= s_valid && (s_res == '0);
                            negative  <= s_valid && s_res[WIDTH-1];
                            carryout  <= s_c;
                            overflow  <= s_v;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    hi    <= n_hi;
                    lo    <= n_lo;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        result    <= m_res;
                        zero      <= (m_res == '0);
                        negative  <= m_res[WIDTH-1];
                        carryout  <= m_c;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        count     <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
